adder_share_arb: RTL and testbench
==================================

ADDER_SHARE_ARB -- requirements
Module: adder_share_arb

Interface
REQ-001: clk, input, 1, rising-edge clock for all state.
REQ-002: rst, input, 1; reset is asynchronous and active-high.
REQ-003: req0, input, 1; requester 0 add request, held high until gnt0.
REQ-004: a0, b0, input, 3 each; requester 0 operands (bit 0 = LSB).
REQ-005: req1, input, 1; requester 1 add request, held high until gnt1.
REQ-006: a1, b1, input, 3 each; requester 1 operands.
REQ-007: gnt0, gnt1, output, 1 each; one-cycle grant pulse; operands captured on the grant edge.
REQ-008: res, output, 4; sum {carry, s2, s1, s0} of the last completed add.
REQ-009: res_id, output, 1; requester owning res (0 or 1).
REQ-010: res_valid, output, 1; one-cycle pulse marking a new res.
REQ-011: busy, output, 1; high whenever FSM is not IDLE.

Function
REQ-012: FSM states: IDLE, ADD, DONE; all outputs registered.
REQ-013: One shared full-adder cell (S = A^B^Cin, Cout = majority(A, B, Cin)) evaluates one bit per cycle; no other adder in the block.
REQ-014: IDLE, no req: stay IDLE; gnt0 = gnt1 = 0.
REQ-015: IDLE, exactly one req high on an edge: grant that requester, capture its a/b into opA/opB, carry = 0, bit index k = 0, go ADD.
REQ-016: IDLE, both reqs high: grant the requester not granted last (round-robin); last_id updated on every grant.
REQ-017: gnt pulse high exactly during the first ADD cycle.
REQ-018: ADD, each cycle: res bit k = opA[k]^opB[k]^carry; carry = Cout; k = k+1.
REQ-019: ADD with k = 2: after bit 2 also set res[3] = Cout, res_id = granted id, go DONE.
REQ-020: DONE: res_valid = 1 for that one cycle, then go IDLE.
REQ-021: Latency: req sampled at edge E0 gives gnt high E0..E1, ADD E0..E3, res_valid high E3..E4.
REQ-022: Earliest next grant is edge E5, so throughput is one add per 5 cycles.
REQ-023: Requests in ADD or DONE are not granted; they stay pending and are arbitrated at the next IDLE edge.
REQ-024: res and res_id hold their value until the next DONE; res bits are written only in ADD and at the DONE transition.
REQ-025: Operand changes after the grant edge do not affect the add in progress.
REQ-026: Width: 3-bit + 3-bit unsigned gives a 4-bit result with no overflow; max 7+7 = 14.

Reset
REQ-027: rst high forces, asynchronously: state = IDLE, gnt0 = gnt1 = 0, res = 0, res_id = 0, res_valid = 0, busy = 0, carry = 0, k = 0, last_id = 1, so req0 wins the first tie.
REQ-028: rst mid-ADD or mid-DONE aborts the operation: no res_valid, partial result discarded, pending requests re-arbitrated after rst falls.

Verification
REQ-029: After reset, req0 only, a0 = 3, b0 = 5 -> gnt0 pulse, res_valid 3 cycles after gnt rise, res = 4'b1000, res_id = 0.
REQ-030: req1 only, a1 = 7, b1 = 7 -> res = 4'b1110, res_id = 1; a1 = 0, b1 = 0 -> res = 4'b0000.
REQ-031: Both reqs held from reset, req0 (2+3), req1 (4+4) -> gnt0 first (res = 5, id 0), then gnt1 (res = 8, id 1); grants alternate and are 5 cycles apart.
REQ-032: req1 raised during a req0 ADD -> no gnt1 until IDLE; gnt1 at the first IDLE edge; req0 result unaffected.
REQ-033: rst pulse in the second ADD cycle -> no res_valid, res = 0, busy = 0; a held req0 is granted after reset release.
REQ-034: Operands changed the cycle after the grant (a0 from 1 to 6, b0 = 1) -> res = 2.

Source files
------------

// File: rtl/adder_share_arb.sv
// adder_share_arb: two requesters share one full-adder cell. A round-robin arbiter grants
// one requester, whose 3-bit operands are then added bit-serially (one bit per cycle),
// giving a 4-bit result after three ADD cycles and one DONE cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req0/req1  add requests, held until the matching grant
//   a0,b0      requester 0 operands (3 bits)
//   a1,b1      requester 1 operands (3 bits)
//   gnt0/gnt1  one-cycle grant pulses (operands captured on the grant edge)
//   res        4-bit sum {carry, s2, s1, s0} of the last completed add
//   res_id     requester that owns res
//   res_valid  one-cycle pulse marking a new res
//   busy       high whenever the FSM is not idle
module adder_share_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [2:0] a0,
    input  logic [2:0] b0,
    input  logic       req1,
    input  logic [2:0] a1,
    input  logic [2:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [3:0] res,
    output logic       res_id,
    output logic       res_valid,
    output logic       busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] op_a_q, op_a_d;
    logic [2:0] op_b_q, op_b_d;
    logic [2:0] work_q, work_d;     // sum bits being built; only copied to res on completion
    logic       carry_q, carry_d;
    logic [1:0] k_q, k_d;
    logic       cur_id_q, cur_id_d;
    logic       last_id_q, last_id_d;
    logic [3:0] res_q, res_d;
    logic       res_id_q, res_id_d;
    logic       res_valid_q, res_valid_d;
    logic       busy_q, busy_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       pick;

    // The single shared full-adder cell.
    logic fa_a, fa_b, fa_s, fa_c;
    assign fa_a = op_a_q[k_q];
    assign fa_b = op_b_q[k_q];
    assign fa_s = fa_a ^ fa_b ^ carry_q;
    assign fa_c = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        work_d      = work_q;
        carry_d     = carry_q;
        k_d         = k_q;
        cur_id_d    = cur_id_q;
        last_id_d   = last_id_q;
        res_d       = res_q;
        res_id_d    = res_id_q;
        res_valid_d = 1'b0;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        pick        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie, favour the requester that was not granted last.
                    pick      = (req0 && req1) ? ~last_id_q : req1;
                    gnt0_d    = ~pick;
                    gnt1_d    = pick;
                    last_id_d = pick;
                    cur_id_d  = pick;
                    op_a_d    = pick ? a1 : a0;
                    op_b_d    = pick ? b1 : b0;
                    carry_d   = 1'b0;
                    k_d       = 2'd0;
                    state_d   = ADD;
                end
            end
            ADD: begin
                work_d[k_q] = fa_s;
                carry_d     = fa_c;
                k_d         = k_q + 2'd1;
                if (k_q == 2'd2) begin
                    res_d       = {fa_c, fa_s, work_q[1], work_q[0]};
                    res_id_d    = cur_id_q;
                    res_valid_d = 1'b1;
                    k_d         = 2'd0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_a_q      <= 3'd0;
            op_b_q      <= 3'd0;
            work_q      <= 3'd0;
            carry_q     <= 1'b0;
            k_q         <= 2'd0;
            cur_id_q    <= 1'b0;
            last_id_q   <= 1'b1;    // makes req0 win the first tie
            res_q       <= 4'd0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            work_q      <= work_d;
            carry_q     <= carry_d;
            k_q         <= k_d;
            cur_id_q    <= cur_id_d;
            last_id_q   <= last_id_d;
            res_q       <= res_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign res       = res_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed and random stimulus for adder_share_arb, checked against a
// reference model (plain integer sums plus a round-robin "last granted" record).
module tb_adder_share_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [2:0] a0, b0, a1, b1;
    logic       gnt0, gnt1;
    logic [3:0] res;
    logic       res_id, res_valid, busy;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    bit          m_last   = 1'b1;   // model: id granted most recently
    int unsigned wait_cyc;

    always #5 clk = ~clk;

    adder_share_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .res       (res),
        .res_id    (res_id),
        .res_valid (res_valid),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the next grant, predicts it from the current requests, then follows the
    // add to completion. After the grant the granted requester's operands are scrambled
    // (they must not affect the add in flight); optionally its request is dropped and/or
    // the other requester raises a request while the add is busy.
    task automatic txn(input bit drop, input bit raise_other, output int unsigned waited);
        bit         got;
        bit         exp_id;
        logic [3:0] exp_sum;
        got    = 1'b0;
        waited = 0;
        while (!got && waited < 12) begin
            step();
            waited++;
            if (gnt0 || gnt1) got = 1'b1;
        end
        if (!got) begin
            chk("gnt_timeout", 32'd0, 32'd1);
            return;
        end
        exp_id  = (req0 && req1) ? ~m_last : req1;
        exp_sum = exp_id ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
        m_last  = exp_id;
        chk("gnt0", {31'd0, gnt0}, {31'd0, ~exp_id});
        chk("gnt1", {31'd0, gnt1}, {31'd0, exp_id});
        chk("busy_add", {31'd0, busy}, 32'd1);
        if (exp_id) begin
            a1 = 3'($urandom); b1 = 3'($urandom);
            if (drop) req1 = 1'b0;
            if (raise_other && !req0) begin a0 = 3'($urandom); b0 = 3'($urandom); req0 = 1'b1; end
        end else begin
            a0 = 3'($urandom); b0 = 3'($urandom);
            if (drop) req0 = 1'b0;
            if (raise_other && !req1) begin a1 = 3'($urandom); b1 = 3'($urandom); req1 = 1'b1; end
        end
        for (int i = 0; i < 2; i++) begin
            step();
            chk("no_valid_in_add", {31'd0, res_valid}, 32'd0);
            chk("no_gnt_in_add", {30'd0, gnt1, gnt0}, 32'd0);
        end
        step();
        chk("res_valid", {31'd0, res_valid}, 32'd1);
        chk("res", {28'd0, res}, {28'd0, exp_sum});
        chk("res_id", {31'd0, res_id}, {31'd0, exp_id});
        chk("no_gnt_in_done", {30'd0, gnt1, gnt0}, 32'd0);
        step();
        chk("valid_pulse_end", {31'd0, res_valid}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("res_hold", {28'd0, res}, {28'd0, exp_sum});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = 3'd0; b0 = 3'd0; a1 = 3'd0; b1 = 3'd0;
        #2;
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_res", {28'd0, res}, 32'd0);
        chk("rst_res_id", {31'd0, res_id}, 32'd0);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        step(); step();
        rst = 1'b0;

        // No requests: stay idle.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end

        // 3 + 5 from requester 0.
        a0 = 3'd3; b0 = 3'd5; req0 = 1'b1;
        txn(1'b1, 1'b0, wait_cyc);
        chk("r029_res", {28'd0, res}, 32'h8);

        // Requester 1: 7 + 7, then 0 + 0.
        a1 = 3'd7; b1 = 3'd7; req1 = 1'b1;
        txn(1'b1, 1'b0, wait_cyc);
        chk("r030_max", {28'd0, res}, 32'he);
        a1 = 3'd0; b1 = 3'd0; req1 = 1'b1;
        txn(1'b1, 1'b0, wait_cyc);
        chk("r030_zero", {28'd0, res}, 32'h0);

        // Operands change right after the grant (scrambled inside txn).
        a0 = 3'd1; b0 = 3'd1; req0 = 1'b1;
        txn(1'b1, 1'b0, wait_cyc);
        chk("r034_res", {28'd0, res}, 32'h2);

        // Both held through reset: req0 wins first, then strict alternation 5 cycles apart.
        rst = 1'b1;
        a0 = 3'd2; b0 = 3'd3; a1 = 3'd4; b1 = 3'd4; req0 = 1'b1; req1 = 1'b1;
        m_last = 1'b1;
        step();
        rst = 1'b0;
        txn(1'b0, 1'b0, wait_cyc);
        chk("r031_first_res", {28'd0, res}, 32'h5);
        chk("r031_first_id", {31'd0, res_id}, 32'd0);
        txn(1'b0, 1'b0, wait_cyc);
        chk("r031_gap", wait_cyc, 32'd1);
        chk("r031_second_res", {28'd0, res}, 32'h8);
        chk("r031_second_id", {31'd0, res_id}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            txn(1'b0, 1'b0, wait_cyc);
            chk("r031_gap", wait_cyc, 32'd1);
        end
        txn(1'b1, 1'b0, wait_cyc);
        txn(1'b1, 1'b0, wait_cyc);
        chk("r031_drain_gap", wait_cyc, 32'd1);

        // req1 raised during a req0 add: granted at the first idle edge.
        a0 = 3'($urandom); b0 = 3'($urandom); req0 = 1'b1;
        txn(1'b1, 1'b1, wait_cyc);
        txn(1'b1, 1'b0, wait_cyc);
        chk("r032_gap", wait_cyc, 32'd1);

        // Random traffic.
        for (int n = 0; n < 20; n++) begin
            if (!req0 && !req1) begin
                if ($urandom_range(0, 1) == 0) begin
                    a0 = 3'($urandom); b0 = 3'($urandom); req0 = 1'b1;
                end else begin
                    a1 = 3'($urandom); b1 = 3'($urandom); req1 = 1'b1;
                end
            end
            if (!req0 && $urandom_range(0, 1) == 1) begin
                a0 = 3'($urandom); b0 = 3'($urandom); req0 = 1'b1;
            end
            if (!req1 && $urandom_range(0, 1) == 1) begin
                a1 = 3'($urandom); b1 = 3'($urandom); req1 = 1'b1;
            end
            txn(1'b1, 1'($urandom_range(0, 1)), wait_cyc);
        end
        while (req0 || req1) txn(1'b1, 1'b0, wait_cyc);

        // Reset during the second ADD cycle aborts the add; held req0 re-granted afterwards.
        a0 = 3'd6; b0 = 3'd7; req0 = 1'b1;
        wait_cyc = 0;
        while (!gnt0 && wait_cyc < 12) begin step(); wait_cyc++; end
        chk("r033_gnt", {31'd0, gnt0}, 32'd1);
        step();
        rst = 1'b1;
        #1;
        chk("r033_valid", {31'd0, res_valid}, 32'd0);
        chk("r033_res", {28'd0, res}, 32'd0);
        chk("r033_busy", {31'd0, busy}, 32'd0);
        step();
        chk("r033_valid_hold", {31'd0, res_valid}, 32'd0);
        rst = 1'b0;
        m_last = 1'b1;
        txn(1'b1, 1'b0, wait_cyc);
        chk("r033_regrant", wait_cyc, 32'd1);
        chk("r033_res_after", {28'd0, res}, 32'hd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
